// File: rtl/tank_pkg.sv
// Shared types and constants for tank movement: directions, map geometry,
// start tiles and the move arbiter FSM state encoding.
package tank_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD0,
      S_CHK0,
      S_RD1,
      S_CHK1,
      S_COMMIT,
      S_COOL
   } state_t;

   localparam int TILE_SHIFT = 5;
   localparam int MAP_W      = 20;
   localparam int MAP_H      = 15;

   localparam logic [1:0] TILE_FLOOR = 2'd0;

   localparam logic [4:0] TANK1_START_TX = 5'd1;
   localparam logic [3:0] TANK1_START_TY = 4'd13;
   localparam logic [4:0] TANK2_START_TX = 5'd18;
   localparam logic [3:0] TANK2_START_TY = 4'd1;

endpackage

// File: rtl/tile_step.sv
// Combinational one-tile step: current tile plus direction gives the target
// tile and whether it lies inside the map.
module tile_step
   import tank_pkg::*;
#(
   parameter int MAP_W = tank_pkg::MAP_W,
   parameter int MAP_H = tank_pkg::MAP_H
)(
   input  logic [4:0] cur_x,
   input  logic [3:0] cur_y,
   input  logic [1:0] dir,
   output logic [4:0] tgt_x,
   output logic [3:0] tgt_y,
   output logic       in_bounds
);

   localparam logic signed [6:0] W_LIM = 7'(MAP_W);
   localparam logic signed [6:0] H_LIM = 7'(MAP_H);

   logic signed [6:0] nx;
   logic signed [6:0] ny;

   // Widened signed coordinates so stepping off the 0 edge goes negative
   // instead of wrapping to a large in-range value.
   always_comb begin
      nx = signed'({2'b00, cur_x});
      ny = signed'({3'b000, cur_y});
      case (dir_t'(dir))
         DIR_UP:    ny = ny - 7'sd1;
         DIR_DOWN:  ny = ny + 7'sd1;
         DIR_LEFT:  nx = nx - 7'sd1;
         DIR_RIGHT: nx = nx + 7'sd1;
      endcase
      in_bounds = (nx >= 7'sd0) && (nx < W_LIM) && (ny >= 7'sd0) && (ny < H_LIM);
      tgt_x     = nx[4:0];
      tgt_y     = ny[3:0];
   end

endmodule

// File: rtl/tank_move_arbiter.sv
// Sequences tile moves for both tanks over one shared map read port,
// resolving walls, screen edges and tank-vs-tank conflicts before commit.
module tank_move_arbiter
   import tank_pkg::*;
#(
   parameter int MOVE_PERIOD = 8,
   parameter int MAP_W       = tank_pkg::MAP_W,
   parameter int MAP_H       = tank_pkg::MAP_H
)(
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       req1_valid,
   input  logic [1:0] req1_dir,
   input  logic       req2_valid,
   input  logic [1:0] req2_dir,
   output logic       map_rd,
   output logic [8:0] map_addr,
   input  logic [1:0] map_data,
   output logic [4:0] tank1_tx,
   output logic [3:0] tank1_ty,
   output logic [4:0] tank2_tx,
   output logic [3:0] tank2_ty,
   output logic [9:0] Tank1X,
   output logic [9:0] Tank1Y,
   output logic [9:0] Tank2X,
   output logic [9:0] Tank2Y,
   output logic       busy,
   output logic       move_done,
   output logic       blocked1,
   output logic       blocked2
);

   localparam int CNT_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
   localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(MOVE_PERIOD - 1);

   state_t state, state_nxt;

   logic             prio;
   logic             lat_v1, lat_v2;
   logic [1:0]       lat_d1, lat_d2;
   logic             acc0, acc1;
   logic [4:0]       res0_x, res1_x;
   logic [3:0]       res0_y, res1_y;
   logic [CNT_W-1:0] cool_cnt;

   logic       slot1, slot_t2, slot_req, tgt_inb, accept;
   logic [1:0] slot_dir;
   logic [4:0] cur_x, tgt_x, blk_x;
   logic [3:0] cur_y, tgt_y, blk_y;
   logic [8:0] tgt_addr;

   // Slot 1 is checked against slot 0's resolved tile, slot 0 against the
   // other tank's current tile; prio swaps which tank sits in which slot.
   always_comb begin
      slot1    = (state == S_RD1) || (state == S_CHK1);
      slot_t2  = slot1 ^ prio;
      cur_x    = slot_t2 ? tank2_tx : tank1_tx;
      cur_y    = slot_t2 ? tank2_ty : tank1_ty;
      slot_req = slot_t2 ? lat_v2 : lat_v1;
      slot_dir = slot_t2 ? lat_d2 : lat_d1;
      blk_x    = slot1 ? res0_x : (slot_t2 ? tank1_tx : tank2_tx);
      blk_y    = slot1 ? res0_y : (slot_t2 ? tank1_ty : tank2_ty);
   end

   tile_step #(
      .MAP_W (MAP_W),
      .MAP_H (MAP_H)
   ) u_step (
      .cur_x     (cur_x),
      .cur_y     (cur_y),
      .dir       (slot_dir),
      .tgt_x     (tgt_x),
      .tgt_y     (tgt_y),
      .in_bounds (tgt_inb)
   );

   assign tgt_addr = 9'(tgt_y) * 9'(MAP_W) + 9'(tgt_x);
   assign accept   = slot_req && tgt_inb && (map_data == TILE_FLOOR) &&
                     !((tgt_x == blk_x) && (tgt_y == blk_y));

   always_comb begin
      state_nxt = state;
      map_rd    = 1'b0;
      map_addr  = '0;
      case (state)
         S_IDLE:   if (req1_valid || req2_valid) state_nxt = S_RD0;
         S_RD0: begin
            map_rd    = slot_req && tgt_inb;
            state_nxt = S_CHK0;
         end
         S_CHK0:   state_nxt = S_RD1;
         S_RD1: begin
            map_rd    = slot_req && tgt_inb;
            state_nxt = S_CHK1;
         end
         S_CHK1:   state_nxt = S_COMMIT;
         S_COMMIT: state_nxt = S_COOL;
         S_COOL:   if (cool_cnt == COOL_LAST) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      if (map_rd) map_addr = tgt_addr;
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         prio      <= 1'b0;
         lat_v1    <= 1'b0;
         lat_v2    <= 1'b0;
         lat_d1    <= '0;
         lat_d2    <= '0;
         acc0      <= 1'b0;
         acc1      <= 1'b0;
         res0_x    <= '0;
         res0_y    <= '0;
         res1_x    <= '0;
         res1_y    <= '0;
         cool_cnt  <= '0;
         tank1_tx  <= TANK1_START_TX;
         tank1_ty  <= TANK1_START_TY;
         tank2_tx  <= TANK2_START_TX;
         tank2_ty  <= TANK2_START_TY;
         move_done <= 1'b0;
         blocked1  <= 1'b0;
         blocked2  <= 1'b0;
      end else begin
         state     <= state_nxt;
         move_done <= (state == S_COMMIT);
         case (state)
            S_IDLE: begin
               if (req1_valid || req2_valid) begin
                  lat_v1 <= req1_valid;
                  lat_v2 <= req2_valid;
                  lat_d1 <= req1_dir;
                  lat_d2 <= req2_dir;
               end
            end
            S_CHK0: begin
               acc0   <= accept;
               res0_x <= accept ? tgt_x : cur_x;
               res0_y <= accept ? tgt_y : cur_y;
            end
            S_CHK1: begin
               acc1   <= accept;
               res1_x <= accept ? tgt_x : cur_x;
               res1_y <= accept ? tgt_y : cur_y;
            end
            S_COMMIT: begin
               cool_cnt <= '0;
               if (!prio) begin
                  tank1_tx <= res0_x;
                  tank1_ty <= res0_y;
                  tank2_tx <= res1_x;
                  tank2_ty <= res1_y;
                  blocked1 <= lat_v1 && !acc0;
                  blocked2 <= lat_v2 && !acc1;
               end else begin
                  tank1_tx <= res1_x;
                  tank1_ty <= res1_y;
                  tank2_tx <= res0_x;
                  tank2_ty <= res0_y;
                  blocked1 <= lat_v1 && !acc1;
                  blocked2 <= lat_v2 && !acc0;
               end
               if (lat_v1 && lat_v2) prio <= !prio;
            end
            S_COOL:   cool_cnt <= cool_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   assign busy   = (state != S_IDLE);
   assign Tank1X = 10'(tank1_tx) << TILE_SHIFT;
   assign Tank1Y = 10'(tank1_ty) << TILE_SHIFT;
   assign Tank2X = 10'(tank2_tx) << TILE_SHIFT;
   assign Tank2Y = 10'(tank2_ty) << TILE_SHIFT;

endmodule

// File: tb/tb_tank_move_arbiter.sv
// Scoreboard bench for tank_move_arbiter: a behavioural model predicts each
// round's reads and committed positions; monitors capture what the DUT did.
module tb_tank_move_arbiter;
   import tank_pkg::*;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic       req1_valid = 1'b0, req2_valid = 1'b0;
   logic [1:0] req1_dir = 2'd0, req2_dir = 2'd0;
   logic       map_rd;
   logic [8:0] map_addr;
   logic [1:0] map_data = 2'd0;
   logic [4:0] tank1_tx, tank2_tx;
   logic [3:0] tank1_ty, tank2_ty;
   logic [9:0] Tank1X, Tank1Y, Tank2X, Tank2Y;
   logic       busy, move_done, blocked1, blocked2;

   tank_move_arbiter #(.MOVE_PERIOD(8), .MAP_W(20), .MAP_H(15)) dut (
      .frame_clk(frame_clk), .Reset(Reset),
      .req1_valid(req1_valid), .req1_dir(req1_dir),
      .req2_valid(req2_valid), .req2_dir(req2_dir),
      .map_rd(map_rd), .map_addr(map_addr), .map_data(map_data),
      .tank1_tx(tank1_tx), .tank1_ty(tank1_ty),
      .tank2_tx(tank2_tx), .tank2_ty(tank2_ty),
      .Tank1X(Tank1X), .Tank1Y(Tank1Y), .Tank2X(Tank2X), .Tank2Y(Tank2Y),
      .busy(busy), .move_done(move_done),
      .blocked1(blocked1), .blocked2(blocked2)
   );

   always #5 frame_clk = ~frame_clk;

   logic [1:0] ram [0:299];
   always @(posedge frame_clk)
      if (map_rd && map_addr < 9'd300) map_data <= ram[map_addr];

   typedef struct {int x1, y1, x2, y2; logic b1, b2;} exp_t;
   typedef struct {int x1, y1, x2, y2, px1, py1, px2, py2; logic b1, b2; int cyc;} obs_t;

   exp_t exp_q[$];
   obs_t obs_done[$];
   int   exp_rd[$];
   int   obs_rd[$];
   obs_t mon_o;
   int   cyc = 0;
   int   n_checks = 0, n_pass = 0;
   int   mx[2], my[2];
   bit   mprio;

   always @(posedge frame_clk) cyc <= cyc + 1;

   always @(negedge frame_clk) begin
      if (map_rd === 1'b1) obs_rd.push_back(int'(map_addr));
      if (move_done === 1'b1) begin
         mon_o.x1 = int'(tank1_tx);  mon_o.y1 = int'(tank1_ty);
         mon_o.x2 = int'(tank2_tx);  mon_o.y2 = int'(tank2_ty);
         mon_o.px1 = int'(Tank1X);   mon_o.py1 = int'(Tank1Y);
         mon_o.px2 = int'(Tank2X);   mon_o.py2 = int'(Tank2Y);
         mon_o.b1 = blocked1;        mon_o.b2 = blocked2;
         mon_o.cyc = cyc;
         obs_done.push_back(mon_o);
      end
   end

   // Model of one round: slot order from prio, slot 0 checked against the
   // other tank's current tile, slot 1 against slot 0's resolved tile.
   task automatic predict(input bit v1, input logic [1:0] d1, input bit v2, input logic [1:0] d2);
      bit v[2]; int d[2]; int ord[2]; int rx[2], ry[2]; bit acc[2]; exp_t e;
      v[0] = v1; v[1] = v2; d[0] = int'(d1); d[1] = int'(d2);
      ord[0] = mprio ? 1 : 0; ord[1] = mprio ? 0 : 1;
      for (int s = 0; s < 2; s++) begin
         int k, nx, ny, bx, by; bit inb;
         k = ord[s]; nx = mx[k]; ny = my[k];
         case (d[k])
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
         endcase
         inb = (nx >= 0) && (nx < 20) && (ny >= 0) && (ny < 15);
         if (s == 0) begin bx = mx[ord[1]]; by = my[ord[1]]; end
         else begin bx = rx[ord[0]]; by = ry[ord[0]]; end
         acc[k] = 1'b0;
         if (v[k] && inb) begin
            exp_rd.push_back(ny * 20 + nx);
            acc[k] = (ram[ny * 20 + nx] == 2'd0) && !(nx == bx && ny == by);
         end
         rx[k] = acc[k] ? nx : mx[k];
         ry[k] = acc[k] ? ny : my[k];
      end
      e.b1 = v[0] && !acc[0];
      e.b2 = v[1] && !acc[1];
      mx[0] = rx[0]; my[0] = ry[0]; mx[1] = rx[1]; my[1] = ry[1];
      if (v1 && v2) mprio = !mprio;
      e.x1 = mx[0]; e.y1 = my[0]; e.x2 = mx[1]; e.y2 = my[1];
      exp_q.push_back(e);
   endtask

   task automatic wait_idle(input string tag);
      int w = 0;
      @(negedge frame_clk);
      while (busy !== 1'b0 && w < 40) begin @(negedge frame_clk); w++; end
      if (busy !== 1'b0) begin
         n_checks++;
         $display("FAIL %s idle_timeout: busy=%b after 40 cycles, required 0", tag, busy);
      end
   endtask

   // Scoreboard consumer: pop the next observed commit and its prediction.
   task automatic sb_check(input string tag, output int dc);
      int w = 0; obs_t o; exp_t e; bit ok;
      dc = -1;
      while (obs_done.size() == 0 && w < 30) begin @(negedge frame_clk); #1; w++; end
      n_checks++;
      if (obs_done.size() == 0 || exp_q.size() == 0) begin
         $display("FAIL %s done_timeout: commits seen=%0d, required 1", tag, obs_done.size());
         return;
      end
      n_pass++;
      o = obs_done.pop_front(); e = exp_q.pop_front(); dc = o.cyc;
      n_checks++;
      if (o.x1 !== e.x1 || o.y1 !== e.y1)
         $display("FAIL %s tank1_tile: got (%0d,%0d) required (%0d,%0d)", tag, o.x1, o.y1, e.x1, e.y1);
      else n_pass++;
      n_checks++;
      if (o.x2 !== e.x2 || o.y2 !== e.y2)
         $display("FAIL %s tank2_tile: got (%0d,%0d) required (%0d,%0d)", tag, o.x2, o.y2, e.x2, e.y2);
      else n_pass++;
      n_checks++;
      if (o.px1 !== e.x1 * 32 || o.py1 !== e.y1 * 32 || o.px2 !== e.x2 * 32 || o.py2 !== e.y2 * 32)
         $display("FAIL %s pixels: got (%0d,%0d)/(%0d,%0d) required (%0d,%0d)/(%0d,%0d)", tag,
                  o.px1, o.py1, o.px2, o.py2, e.x1 * 32, e.y1 * 32, e.x2 * 32, e.y2 * 32);
      else n_pass++;
      n_checks++;
      if (o.b1 !== e.b1 || o.b2 !== e.b2)
         $display("FAIL %s blocked: got %b%b required %b%b", tag, o.b1, o.b2, e.b1, e.b2);
      else n_pass++;
      ok = (obs_rd.size() == exp_rd.size());
      if (ok) foreach (exp_rd[i]) if (obs_rd[i] != exp_rd[i]) ok = 1'b0;
      n_checks++;
      if (!ok)
         $display("FAIL %s map_reads: got %0d reads (first %0d) required %0d reads (first %0d)", tag,
                  obs_rd.size(), (obs_rd.size() > 0) ? obs_rd[0] : -1,
                  exp_rd.size(), (exp_rd.size() > 0) ? exp_rd[0] : -1);
      else n_pass++;
      obs_rd.delete(); exp_rd.delete();
   endtask

   task automatic do_move(input bit v1, input logic [1:0] d1, input bit v2, input logic [1:0] d2,
                          input string tag);
      int e0, dc;
      wait_idle(tag);
      predict(v1, d1, v2, d2);
      req1_valid = v1; req1_dir = d1; req2_valid = v2; req2_dir = d2;
      @(posedge frame_clk); #1 e0 = cyc;
      @(negedge frame_clk);
      req1_valid = 1'b0; req2_valid = 1'b0;
      sb_check(tag, dc);
      n_checks++;
      if (dc - e0 !== 5) $display("FAIL %s latency: got %0d edges required 5", tag, dc - e0);
      else n_pass++;
      @(negedge frame_clk);
      n_checks++;
      if (move_done !== 1'b0) $display("FAIL %s done_width: move_done=%b second cycle, required 0", tag, move_done);
      else n_pass++;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      mx[0] = 1; my[0] = 13; mx[1] = 18; my[1] = 1; mprio = 1'b0;
      repeat (3) @(negedge frame_clk);
      n_checks++;
      if (Tank1X !== 10'd32 || Tank1Y !== 10'd416 || Tank2X !== 10'd576 || Tank2Y !== 10'd32)
         $display("FAIL reset_pixels: got (%0d,%0d)/(%0d,%0d) required (32,416)/(576,32)",
                  Tank1X, Tank1Y, Tank2X, Tank2Y);
      else n_pass++;
      n_checks++;
      if ({busy, move_done, blocked1, blocked2, map_rd} !== 5'b0)
         $display("FAIL reset_flags: got busy/done/b1/b2/rd=%b required 00000",
                  {busy, move_done, blocked1, blocked2, map_rd});
      else n_pass++;
      Reset = 1'b0;
      obs_rd.delete();
      for (int i = 0; i < 10; i++) begin
         @(negedge frame_clk);
         n_checks++;
         if (busy !== 1'b0) $display("FAIL idle_busy: cycle %0d busy=%b required 0", i, busy);
         else n_pass++;
      end
      n_checks++;
      if (obs_rd.size() != 0) $display("FAIL idle_map_rd: got %0d reads required 0", obs_rd.size());
      else n_pass++;
   endtask

   task automatic test_single_move();
      do_move(1'b1, DIR_RIGHT, 1'b0, DIR_UP, "right_move");
      n_checks++;
      if (tank1_tx !== 5'd2 || Tank1X !== 10'd64) $display("FAIL right_pos: got tx=%0d X=%0d required 2/64", tank1_tx, Tank1X);
      else n_pass++;
   endtask

   task automatic test_wall();
      do_move(1'b1, DIR_LEFT, 1'b0, DIR_UP, "back_left");
      ram[12 * 20 + 1] = 2'd1;
      do_move(1'b1, DIR_UP, 1'b0, DIR_UP, "wall_up");
      n_checks++;
      if (blocked1 !== 1'b1 || tank1_ty !== 4'd13) $display("FAIL wall_block: got b1=%b ty=%0d required 1/13", blocked1, tank1_ty);
      else n_pass++;
      ram[12 * 20 + 1] = 2'd0;
   endtask

   task automatic test_edge();
      do_move(1'b1, DIR_LEFT, 1'b0, DIR_UP, "to_col0");
      for (int i = 0; i < 8; i++) do_move(1'b1, DIR_UP, 1'b0, DIR_UP, "climb");
      do_move(1'b1, DIR_LEFT, 1'b0, DIR_UP, "edge_left");
      n_checks++;
      if (blocked1 !== 1'b1 || tank1_tx !== 5'd0 || tank1_ty !== 4'd5)
         $display("FAIL edge_block: got b1=%b tile=(%0d,%0d) required 1/(0,5)", blocked1, tank1_tx, tank1_ty);
      else n_pass++;
   endtask

   task automatic test_contest();
      for (int i = 0; i < 5; i++) do_move(1'b1, DIR_RIGHT, 1'b0, DIR_UP, "t1_pos");
      for (int i = 0; i < 4; i++) do_move(1'b0, DIR_UP, 1'b1, DIR_DOWN, "t2_down");
      for (int i = 0; i < 11; i++) do_move(1'b0, DIR_UP, 1'b1, DIR_LEFT, "t2_left");
      do_move(1'b1, DIR_RIGHT, 1'b1, DIR_LEFT, "contest_p0");
      n_checks++;
      if (tank1_tx !== 5'd6 || blocked2 !== 1'b1 || tank2_tx !== 5'd7)
         $display("FAIL contest_p0: got t1x=%0d b2=%b t2x=%0d required 6/1/7", tank1_tx, blocked2, tank2_tx);
      else n_pass++;
      do_move(1'b1, DIR_RIGHT, 1'b1, DIR_LEFT, "contest_p1");
      n_checks++;
      if ({blocked1, blocked2} !== 2'b11) $display("FAIL contest_p1: got blocked=%b%b required 11", blocked1, blocked2);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int dc[3];
      wait_idle("b2b");
      predict(1'b1, DIR_DOWN, 1'b0, DIR_UP);
      req1_valid = 1'b1; req1_dir = DIR_DOWN;
      for (int i = 0; i < 3; i++) begin
         sb_check("b2b", dc[i]);
         if (i < 2) predict(1'b1, DIR_DOWN, 1'b0, DIR_UP);
      end
      req1_valid = 1'b0;
      for (int i = 1; i < 3; i++) begin
         n_checks++;
         if (dc[i] - dc[i-1] !== 14) $display("FAIL b2b_spacing: gap %0d got %0d cycles required 14", i, dc[i] - dc[i-1]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      wait_idle("reset_mid");
      req1_valid = 1'b1; req1_dir = DIR_DOWN;
      @(posedge frame_clk);
      @(negedge frame_clk);
      req1_valid = 1'b0;
      repeat (3) @(posedge frame_clk);
      @(negedge frame_clk);
      Reset = 1'b1;
      #1;
      n_checks++;
      if (tank1_tx !== 5'd1 || tank1_ty !== 4'd13 || tank2_tx !== 5'd18 || tank2_ty !== 4'd1 || busy !== 1'b0)
         $display("FAIL reset_mid_state: got (%0d,%0d)/(%0d,%0d) busy=%b required (1,13)/(18,1) 0",
                  tank1_tx, tank1_ty, tank2_tx, tank2_ty, busy);
      else n_pass++;
      @(negedge frame_clk);
      Reset = 1'b0;
      mx[0] = 1; my[0] = 13; mx[1] = 18; my[1] = 1; mprio = 1'b0;
      obs_rd.delete(); exp_rd.delete();
      repeat (20) @(negedge frame_clk);
      n_checks++;
      if (obs_done.size() != 0) $display("FAIL reset_mid_done: got %0d move_done pulses required 0", obs_done.size());
      else n_pass++;
      do_move(1'b1, DIR_UP, 1'b1, DIR_DOWN, "after_reset");
   endtask

   initial begin
      for (int i = 0; i < 300; i++) ram[i] = 2'd0;
      test_reset();
      test_single_move();
      test_wall();
      test_edge();
      test_contest();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
